// File: rtl/pcpi_dispatch_if.sv
// Signal bundle between the CPU's PCPI port, the dispatcher and the two coprocessor slots.
// The slave modport is the dispatcher's view; master is the surrounding core/slot side.
interface pcpi_dispatch_if;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic        pcpi_timeout;

    logic        cp_valid;
    logic [31:0] cp_insn;
    logic [31:0] cp_rs1;
    logic [31:0] cp_rs2;

    logic        cp0_wr;
    logic [31:0] cp0_rd;
    logic        cp0_wait;
    logic        cp0_ready;
    logic        cp1_wr;
    logic [31:0] cp1_rd;
    logic        cp1_wait;
    logic        cp1_ready;

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
        output cp_valid, cp_insn, cp_rs1, cp_rs2,
        input  cp0_wr, cp0_rd, cp0_wait, cp0_ready,
        input  cp1_wr, cp1_rd, cp1_wait, cp1_ready
    );

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
        input  cp_valid, cp_insn, cp_rs1, cp_rs2,
        output cp0_wr, cp0_rd, cp0_wait, cp0_ready,
        output cp1_wr, cp1_rd, cp1_wait, cp1_ready
    );
endinterface

// File: rtl/pcpi_dispatch.sv
// Routes one PCPI request at a time to a multiplier (slot 0) or divider (slot 1),
// returns the winning result to the CPU and times out when no slot claims the instruction.
module pcpi_dispatch #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          SLOT1_EN       = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    pcpi_dispatch_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      insn_q, insn_d;
    logic [31:0]      rs1_q, rs1_d;
    logic [31:0]      rs2_q, rs2_d;
    logic [31:0]      rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             ready_q, ready_d;
    logic             timeout_q, timeout_d;

    logic             s1_ready;
    logic             s1_wr;
    logic [31:0]      s1_rd;
    logic             any_wait;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // A disabled slot 1 looks permanently silent.
    assign s1_ready = SLOT1_EN & bus.cp1_ready;
    assign s1_wr    = SLOT1_EN & bus.cp1_wr;
    assign s1_rd    = SLOT1_EN ? bus.cp1_rd : 32'd0;
    assign any_wait = bus.cp0_wait | (SLOT1_EN & bus.cp1_wait);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        insn_d    = insn_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        wr_d      = 1'b0;
        ready_d   = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.pcpi_valid) begin
                    insn_d  = bus.pcpi_insn;
                    rs1_d   = bus.pcpi_rs1;
                    rs2_d   = bus.pcpi_rs2;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Abort wins over everything; then slot 0, slot 1, and timeout last.
                if (!bus.pcpi_valid) begin
                    state_d = IDLE;
                end else if (bus.cp0_ready) begin
                    wr_d    = bus.cp0_wr;
                    rd_d    = bus.cp0_rd;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else if (s1_ready) begin
                    wr_d    = s1_wr;
                    rd_d    = s1_rd;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else if (!any_wait && (cnt_q == CNT_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    cnt_d = any_wait ? '0 : sat_inc(cnt_q);
                end
            end
            DONE: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                // Holding here until valid drops keeps a lingering request from re-issuing.
                if (!bus.pcpi_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            insn_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wr_q      <= 1'b0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            insn_q    <= insn_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.cp_valid     = (state_q == ISSUE);
    assign bus.cp_insn      = insn_q;
    assign bus.cp_rs1       = rs1_q;
    assign bus.cp_rs2       = rs2_q;
    assign bus.pcpi_wait    = (state_q == ISSUE) || (state_q == DONE);
    assign bus.pcpi_ready   = ready_q;
    assign bus.pcpi_wr      = wr_q;
    assign bus.pcpi_rd      = rd_q;
    assign bus.pcpi_timeout = timeout_q;
endmodule
